stage_progress: RTL and testbench

//  Downstream consumer of the player-bullet block's hit-point outputs (enmhp1-4, bosshp).

---
 rtl/stage_progress.sv | 191 +++++++++++++++++++
 tb/tb_stage_progress.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_progress.sv
// stage_progress: stage sequencer fed by the bullet block's hit-point outputs.
// Runs wave -> boss intro -> boss -> clear/over, keeps score, lives and the
// respawn window, and drives the player/bullet enable back upstream.
//
//   state      | meaning
//   -----------+------------------------------------------------
//   IDLE   (0) | waiting for start; score/lives shown as held
//   WAVE   (1) | four enemies on screen, kills scored
//   INTRO  (2) | boss entrance, player disabled for INTRO_CYCLES
//   BOSS   (3) | boss fight, damage and kill scored
//   CLEAR  (4) | boss defeated, waiting for start
//   OVER   (5) | out of lives, waiting for start
module stage_progress #(
    parameter int unsigned INTRO_CYCLES   = 256,
    parameter int unsigned RESPAWN_CYCLES = 128,
    parameter int unsigned ENM_SCORE      = 100,
    parameter int unsigned BOSS_SCORE     = 5000,
    parameter int unsigned LIVES_INIT     = 3
) (
    input  logic        clk_22_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        player_hit_i,
    input  logic [6:0]  enmhp1_i,
    input  logic [6:0]  enmhp2_i,
    input  logic [6:0]  enmhp3_i,
    input  logic [6:0]  enmhp4_i,
    input  logic [9:0]  bosshp_i,
    output logic [2:0]  state_o,
    output logic        reimuE_o,
    output logic [3:0]  enm_alive_o,
    output logic [3:0]  enm_explode_o,
    output logic        boss_active_o,
    output logic [15:0] score_o,
    output logic [1:0]  lives_o
);

    localparam int INTRO_W = (INTRO_CYCLES > 1) ? $clog2(INTRO_CYCLES) : 1;
    localparam int RESP_W  = $clog2(RESPAWN_CYCLES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAVE  = 3'd1;
    localparam logic [2:0] S_INTRO = 3'd2;
    localparam logic [2:0] S_BOSS  = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [15:0]        score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic [RESP_W-1:0]  resp_q, resp_d;
    logic [INTRO_W-1:0] intro_q, intro_d;
    logic [6:0]         prev_enm_q [4];
    logic [9:0]         prev_boss_q;
    logic               reimu_q;
    logic [3:0]         alive_q;
    logic [3:0]         explode_q;
    logic               boss_act_q;

    logic [6:0]         enm_hp [4];
    logic [3:0]         hp_nz;
    logic [3:0]         kill;
    logic [2:0]         n_kill;
    logic               boss_dmg;
    logic               boss_kill;
    logic               hit_ok;
    logic [17:0]        add;
    logic [17:0]        sum;
    logic [15:0]        score_sat;

    assign enm_hp[0] = enmhp1_i;
    assign enm_hp[1] = enmhp2_i;
    assign enm_hp[2] = enmhp3_i;
    assign enm_hp[3] = enmhp4_i;

    // Kill/damage detection against last cycle's hit points, and the saturated score sum.
    always_comb begin
        n_kill = 3'd0;
        for (int i = 0; i < 4; i++) begin
            hp_nz[i] = (enm_hp[i] != 7'd0);
            kill[i]  = (state_q == S_WAVE) && (prev_enm_q[i] != 7'd0) && !hp_nz[i];
            n_kill   = n_kill + {2'b00, kill[i]};
        end
        boss_dmg  = (state_q == S_BOSS) && (bosshp_i < prev_boss_q);
        boss_kill = (state_q == S_BOSS) && (bosshp_i == 10'd0);
        // A hit only counts while the player is actually enabled.
        hit_ok    = ((state_q == S_WAVE) || (state_q == S_BOSS)) && reimu_q && player_hit_i;
        add       = ({15'd0, n_kill} * 18'(ENM_SCORE))
                  + {17'd0, boss_dmg}
                  + (boss_kill ? 18'(BOSS_SCORE) : 18'd0);
        sum       = {2'b00, score_q} + add;
        score_sat = (sum > 18'h0FFFF) ? 16'hFFFF : sum[15:0];
    end

    // Next-state, score, lives and timer decisions.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        intro_d = intro_q;
        resp_d  = (resp_q != '0) ? resp_q - RESP_W'(1) : '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_WAVE;
                    score_d = 16'd0;
                    lives_d = 2'(LIVES_INIT);
                    resp_d  = '0;
                end
            end
            S_WAVE: begin
                score_d = score_sat;
                if (hp_nz == 4'b0000) begin
                    state_d = S_INTRO;
                    intro_d = '0;
                end
            end
            S_INTRO: begin
                intro_d = intro_q + INTRO_W'(1);
                if (intro_q == INTRO_W'(INTRO_CYCLES - 1)) begin
                    state_d = S_BOSS;
                end
            end
            S_BOSS: begin
                score_d = score_sat;
                if (boss_kill) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR, S_OVER: begin
                if (start_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Losing the last life overrides any wave/boss completion in the same cycle,
        // while the kill score computed above still stands.
        if (hit_ok) begin
            lives_d = lives_q - 2'd1;
            resp_d  = RESP_W'(RESPAWN_CYCLES);
            if (lives_q == 2'd1) begin
                state_d = S_OVER;
            end
        end
    end

    // State and registered outputs; output flags are derived from the next state.
    always_ff @(posedge clk_22_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            score_q     <= 16'd0;
            lives_q     <= 2'd0;
            resp_q      <= '0;
            intro_q     <= '0;
            prev_boss_q <= 10'd0;
            reimu_q     <= 1'b0;
            alive_q     <= 4'd0;
            explode_q   <= 4'd0;
            boss_act_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                prev_enm_q[i] <= 7'd0;
            end
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            resp_q      <= resp_d;
            intro_q     <= intro_d;
            prev_boss_q <= bosshp_i;
            reimu_q     <= ((state_d == S_WAVE) || (state_d == S_BOSS)) && (resp_d == '0);
            alive_q     <= (state_d == S_WAVE) ? hp_nz : 4'd0;
            explode_q   <= kill;
            boss_act_q  <= (state_d == S_INTRO) || (state_d == S_BOSS);
            for (int i = 0; i < 4; i++) begin
                prev_enm_q[i] <= enm_hp[i];
            end
        end
    end

    assign state_o       = state_q;
    assign reimuE_o      = reimu_q;
    assign enm_alive_o   = alive_q;
    assign enm_explode_o = explode_q;
    assign boss_active_o = boss_act_q;
    assign score_o       = score_q;
    assign lives_o       = lives_q;

endmodule

// File: tb/tb_stage_progress.sv
// Testbench for stage_progress: fixed vector table, directed multi-cycle
// sequences and a randomized run, all checked against a game-rule model.
module tb_stage_progress;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, hit;
    logic [6:0]  ehp [4];
    logic [9:0]  bh;
    logic [2:0]  state_o;
    logic        reimu_o, bact_o;
    logic [3:0]  alive_o, expl_o;
    logic [15:0] score_o;
    logic [1:0]  lives_o;

    stage_progress dut (
        .clk_22_i     (clk),
        .rst_i        (rst),
        .start_i      (start),
        .player_hit_i (hit),
        .enmhp1_i     (ehp[0]),
        .enmhp2_i     (ehp[1]),
        .enmhp3_i     (ehp[2]),
        .enmhp4_i     (ehp[3]),
        .bosshp_i     (bh),
        .state_o      (state_o),
        .reimuE_o     (reimu_o),
        .enm_alive_o  (alive_o),
        .enm_explode_o(expl_o),
        .boss_active_o(bact_o),
        .score_o      (score_o),
        .lives_o      (lives_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- game-rule reference model ----------------
    // States as numbers: 0 idle, 1 wave, 2 intro, 3 boss, 4 clear, 5 over.
    int m_state, m_score, m_lives, m_resp, m_intro, m_prevb;
    int m_prev [4];
    int m_reimu, m_alive, m_expl, m_bact;

    task automatic model_step();
        int ns, add, kmask, nresp, zeros;
        bit playing;
        if (rst) begin
            m_state = 0; m_score = 0; m_lives = 0; m_resp = 0; m_intro = 0;
            m_reimu = 0; m_alive = 0; m_expl = 0; m_bact = 0; m_prevb = 0;
            for (int i = 0; i < 4; i++) m_prev[i] = 0;
            return;
        end
        ns = m_state; add = 0; kmask = 0; zeros = 0;
        nresp = (m_resp > 0) ? m_resp - 1 : 0;
        playing = (m_state == 1) || (m_state == 3);
        for (int i = 0; i < 4; i++) begin
            if (int'(ehp[i]) == 0) zeros++;
            if (m_state == 1 && m_prev[i] != 0 && int'(ehp[i]) == 0) begin
                kmask = kmask | (1 << i);
                add   = add + 100;
            end
        end
        if (m_state == 3) begin
            if (int'(bh) < m_prevb) add = add + 1;
            if (int'(bh) == 0) begin add = add + 5000; ns = 4; end
        end
        case (m_state)
            0: if (start) begin ns = 1; m_score = 0; m_lives = 3; nresp = 0; end
            1: if (zeros == 4) begin ns = 2; m_intro = 0; end
            2: begin if (m_intro == 255) ns = 3; m_intro = m_intro + 1; end
            4, 5: if (start) ns = 0;
            default: ;
        endcase
        m_score = (m_score + add > 65535) ? 65535 : m_score + add;
        if (playing && m_reimu == 1 && hit) begin
            if (m_lives == 1) ns = 5;
            m_lives = m_lives - 1;
            nresp = 128;
        end
        m_state = ns;
        m_resp  = nresp;
        m_reimu = ((ns == 1 || ns == 3) && nresp == 0) ? 1 : 0;
        m_alive = 0;
        if (ns == 1)
            for (int i = 0; i < 4; i++) if (int'(ehp[i]) != 0) m_alive = m_alive | (1 << i);
        m_expl  = kmask;
        m_bact  = (ns == 2 || ns == 3) ? 1 : 0;
        m_prevb = int'(bh);
        for (int i = 0; i < 4; i++) m_prev[i] = int'(ehp[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("state",   int'(state_o), m_state);
        chk("score",   int'(score_o), m_score);
        chk("lives",   int'(lives_o), m_lives);
        chk("reimuE",  int'(reimu_o), m_reimu);
        chk("alive",   int'(alive_o), m_alive);
        chk("explode", int'(expl_o),  m_expl);
        chk("boss_act",int'(bact_o),  m_bact);
    endtask

    task automatic set_hp(input logic [6:0] v);
        for (int i = 0; i < 4; i++) ehp[i] = v;
    endtask

    // ---------------- fixed vector table ----------------
    typedef struct {
        logic        rst, start, hit;
        logic [6:0]  h1, h2, h3, h4;
        logic [2:0]  st;
        logic [15:0] sc;
        logic [1:0]  lv;
        logic        re;
        logic [3:0]  al, ex;
        logic        ba;
    } vec_t;

    vec_t vt [9];

    initial begin
        int guard, intro_n;
        bit ph;

        vt[0] = '{1'b1, 1'b0, 1'b0, 7'd120, 7'd120, 7'd120, 7'd120, 3'd0, 16'd0,   2'd0, 1'b0, 4'h0, 4'h0, 1'b0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 7'd120, 7'd120, 7'd120, 7'd120, 3'd1, 16'd0,   2'd3, 1'b1, 4'hF, 4'h0, 1'b0};
        vt[2] = '{1'b0, 1'b0, 1'b1, 7'd120, 7'd120, 7'd120, 7'd120, 3'd1, 16'd0,   2'd2, 1'b0, 4'hF, 4'h0, 1'b0};
        vt[3] = '{1'b0, 1'b0, 1'b0, 7'd120, 7'd0,   7'd120, 7'd120, 3'd1, 16'd100, 2'd2, 1'b0, 4'hD, 4'h2, 1'b0};
        vt[4] = '{1'b0, 1'b0, 1'b0, 7'd120, 7'd0,   7'd120, 7'd120, 3'd1, 16'd100, 2'd2, 1'b0, 4'hD, 4'h0, 1'b0};
        vt[5] = '{1'b0, 1'b0, 1'b0, 7'd0,   7'd0,   7'd0,   7'd120, 3'd1, 16'd300, 2'd2, 1'b0, 4'h8, 4'h5, 1'b0};
        vt[6] = '{1'b0, 1'b0, 1'b0, 7'd0,   7'd0,   7'd0,   7'd0,   3'd2, 16'd400, 2'd2, 1'b0, 4'h0, 4'h8, 1'b1};
        vt[7] = '{1'b1, 1'b0, 1'b0, 7'd0,   7'd0,   7'd0,   7'd0,   3'd0, 16'd0,   2'd0, 1'b0, 4'h0, 4'h0, 1'b0};
        vt[8] = '{1'b0, 1'b0, 1'b0, 7'd0,   7'd0,   7'd0,   7'd0,   3'd0, 16'd0,   2'd0, 1'b0, 4'h0, 4'h0, 1'b0};

        bh = 10'd450;
        for (int k = 0; k < 9; k++) begin
            rst = vt[k].rst; start = vt[k].start; hit = vt[k].hit;
            ehp[0] = vt[k].h1; ehp[1] = vt[k].h2; ehp[2] = vt[k].h3; ehp[3] = vt[k].h4;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_state", k),   int'(state_o), int'(vt[k].st));
            chk($sformatf("vec%0d_score", k),   int'(score_o), int'(vt[k].sc));
            chk($sformatf("vec%0d_lives", k),   int'(lives_o), int'(vt[k].lv));
            chk($sformatf("vec%0d_reimuE", k),  int'(reimu_o), int'(vt[k].re));
            chk($sformatf("vec%0d_alive", k),   int'(alive_o), int'(vt[k].al));
            chk($sformatf("vec%0d_explode", k), int'(expl_o),  int'(vt[k].ex));
            chk($sformatf("vec%0d_boss_act", k),int'(bact_o),  int'(vt[k].ba));
        end

        // ---------------- full stage: wave, intro length, boss scoring ----------------
        rst = 1'b1; start = 1'b0; hit = 1'b0; set_hp(7'd120); bh = 10'd450;
        tick();
        rst = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        set_hp(7'd0);
        tick();
        chk("intro_entry", int'(state_o), 2);
        intro_n = 1; guard = 0;
        while (state_o == 3'd2 && guard < 400) begin
            tick();
            if (state_o == 3'd2) intro_n++;
            guard++;
        end
        chk("intro_len", intro_n, 256);
        chk("boss_state", int'(state_o), 3);
        chk("boss_reimuE", int'(reimu_o), 1);
        bh = 10'd449; tick();
        bh = 10'd448; tick();
        chk("boss_dmg_score", int'(score_o), 402);
        // The killing blow is itself a drop in boss hp, so it earns the damage point too.
        bh = 10'd0; tick();
        chk("boss_kill_state", int'(state_o), 4);
        chk("boss_kill_score", int'(score_o), 402 + 1 + 5000);
        tick();
        chk("clear_hold_score", int'(score_o), 5403);

        // ---------------- restart, saturation, lives, last kill with final hit ----------------
        set_hp(7'd120); bh = 10'd450; start = 1'b1;
        tick();
        chk("clear_to_idle", int'(state_o), 0);
        tick();
        chk("restart_score", int'(score_o), 0);
        chk("restart_lives", int'(lives_o), 3);
        start = 1'b0;
        guard = 0; ph = 1'b0;
        while (m_score < 65535 && guard < 400) begin
            ehp[0] = ph ? 7'd120 : 7'd0; ehp[1] = ehp[0];
            ehp[2] = ph ? 7'd0 : 7'd120; ehp[3] = ehp[2];
            tick();
            ph = !ph; guard++;
        end
        chk("sat_reached_in_budget", (guard < 400) ? 1 : 0, 1);
        ehp[0] = ph ? 7'd120 : 7'd0; ehp[1] = ehp[0];
        ehp[2] = ph ? 7'd0 : 7'd120; ehp[3] = ehp[2];
        tick();
        chk("score_saturated", int'(score_o), 16'hFFFF);
        set_hp(7'd120);
        tick();
        hit = 1'b1; tick(); hit = 1'b0;
        chk("hit1_lives", int'(lives_o), 2);
        chk("hit1_reimuE", int'(reimu_o), 0);
        repeat (50) tick();
        hit = 1'b1; tick(); hit = 1'b0;
        chk("hit_in_respawn_lives", int'(lives_o), 2);
        repeat (130) tick();
        chk("respawn_done_reimuE", int'(reimu_o), 1);
        hit = 1'b1; tick(); hit = 1'b0;
        chk("hit2_lives", int'(lives_o), 1);
        repeat (130) tick();
        ehp[0] = 7'd0; ehp[1] = 7'd0; ehp[2] = 7'd0;
        tick();
        ehp[3] = 7'd0; hit = 1'b1;
        tick();
        hit = 1'b0;
        chk("final_hit_over", int'(state_o), 5);
        chk("final_kill_explode", int'(expl_o), 4'b1000);
        chk("final_score_held", int'(score_o), 16'hFFFF);
        chk("final_lives", int'(lives_o), 0);
        repeat (3) tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("over_to_idle", int'(state_o), 0);

        // ---------------- randomized play ----------------
        set_hp(7'd100); bh = 10'd900;
        for (int n = 0; n < 4000; n++) begin
            rst   = ($urandom_range(499, 0) == 0);
            start = ($urandom_range(15, 0) == 0);
            hit   = ($urandom_range(39, 0) == 0);
            for (int i = 0; i < 4; i++) begin
                if (ehp[i] != 7'd0 && $urandom_range(9, 0) == 0) ehp[i] = 7'd0;
                else if (ehp[i] == 7'd0 && $urandom_range(39, 0) == 0) ehp[i] = 7'($urandom_range(127, 1));
                else if (ehp[i] > 7'd3 && $urandom_range(3, 0) == 0) ehp[i] = ehp[i] - 7'd3;
            end
            if (bh == 10'd0) begin
                if ($urandom_range(29, 0) == 0) bh = 10'($urandom_range(1023, 1));
            end else if ($urandom_range(149, 0) == 0) begin
                bh = 10'd0;
            end else if ($urandom_range(1, 0) == 0) begin
                bh = (bh > 10'd3) ? bh - 10'($urandom_range(3, 1)) : 10'd0;
            end else if (bh < 10'd1000 && $urandom_range(7, 0) == 0) begin
                bh = bh + 10'd5;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
